// File: rtl/acc_display_driver.sv
// Accumulator value -> 4-digit multiplexed common-anode 7-seg display via sequential double-dabble.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits (ones digit always shown).
module acc_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [15:0] D,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t        state;
  logic [15:0]   last, snap, dig;
  logic [19:0]   bcd, bcd_adj;
  logic [3:0]    cnt;
  logic [RW-1:0] rcnt;
  logic [1:0]    idx;
  logic [3:0]    cur;
  logic          lz;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      last  <= '0;
      snap  <= '0;
      bcd   <= '0;
      cnt   <= '0;
      dig   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (D != last) begin
          snap  <= D;
          last  <= D;
          bcd   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd  <= {bcd_adj[18:0], snap[15]};
          snap <= {snap[14:0], 1'b0};
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) state <= DONE;
        end
        DONE: begin
          dig   <= bcd[15:0];
          ovf   <= (bcd[19:16] != 4'd0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Refresh scanner runs freely, independent of the converter.
  always_ff @(posedge clk) begin
    if (clear) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    cur = dig[{idx, 2'b00} +: 4];
`ifdef LEAD_ZERO_BLANK_EN
    case (idx)
      2'd1:    lz = (dig[15:4]  == 12'd0);
      2'd2:    lz = (dig[15:8]  == 8'd0);
      2'd3:    lz = (dig[15:12] == 4'd0);
      default: lz = 1'b0;
    endcase
`else
    lz = 1'b0;
`endif
    an  = ~(4'b0001 << idx);
    seg = ovf ? SEG_DASH : (lz ? SEG_BLANK : seg7(cur));
  end

endmodule

// File: doc/acc_display_driver.md
# acc_display_driver

Reads the 16-bit accumulator value and drives a 4-digit, common-anode, multiplexed 7-segment display in unsigned decimal. It sits downstream of the accumulator register and consumes its Q output. A sequential double-dabble converter turns a changed value into BCD, latches the digits glitch-free, and a refresh scanner time-multiplexes them onto the display. Values above 9999 raise an overflow flag and show dashes.

## Interface
- REFRESH_DIV, 50000, clock cycles each digit stays lit (≥2)
- clk  input  1  system clock, all logic on posedge
- clear  input  1  synchronous, active-high reset
- D  input  16  accumulator value (unsigned)
- an  output  4  digit enables, active-low; an[0] = rightmost (ones) digit
- seg  output  7  segments active-low, seg[6:0] = {g,f,e,d,c,b,a}
- busy  output  1  high while a conversion is in progress (SHIFT or DONE)
- ovf  output  1  high while the displayed value is ≥ 10000

## Operation
- Converter FSM states: IDLE, SHIFT, DONE.
- IDLE: if D ≠ last, then snap ← D, last ← D, bcd (20 bits) ← 0, cnt ← 0, go to SHIFT. Otherwise stay.
- SHIFT: each cycle, add 3 to every bcd nibble ≥ 5, then shift {bcd, snap} left by 1. After the 16th shift (cnt = 15), go to DONE.
- DONE: dig[3:0] ← bcd[15:0], ovf ← (bcd[19:16] ≠ 0), go to IDLE.
- D changes during SHIFT/DONE are ignored. They are re-compared in IDLE on the next cycle, so the last stable D is always converted eventually.
- Display digits only change in DONE. The scanner never shows partial results.
- Scanner:
  - rcnt counts 0..REFRESH_DIV-1.
  - When rcnt hits terminal, rcnt ← 0 and idx ← idx+1 mod 4.
  - an = ~(4'b0001 << idx). Scanning is independent of the converter.
- Segment decode, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - dash = 0111111, blank = 1111111
- ovf = 1: every digit shows dash.

## Timing
- Reset (clear = 1 at an edge):
  - state IDLE, last = 0, dig = 0000, ovf = 0, busy = 0, idx = 0, rcnt = 0
  - an = 1110, seg = 1000000
- clear has priority over all activity, including mid-conversion. The aborted conversion is discarded and dig returns to 0.
- D = 0 after reset triggers no conversion, because last = 0.
- Latency: D differs from last at edge N (IDLE).
  - busy rises after edge N.
  - Shifts occur on edges N+1..N+16.
  - dig and ovf update at edge N+17. busy falls after edge N+17.
- busy is a registered state decode (SHIFT or DONE).
- an and seg are combinational from idx, dig, and ovf. They change only on clock edges.

## Configuration
- LEAD_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero digit show blank.
  - The ones digit is always shown, so value 0 displays a single "0".
  - Dashes under ovf are unaffected.
- LEAD_ZERO_BLANK_EN undefined: all four digits always show, with leading zeros.

## Test plan
Bench uses REFRESH_DIV = 4.
- Reset: hold clear 2 cycles with D = 0 → an = 1110, seg = 1000000, busy = 0, ovf = 0; busy stays 0 for 20 cycles.
- D = 1234 after reset → busy for exactly 17 cycles (edges N through N+16 leave it high). Then the scan shows:
  - an = 1110 with seg = 0011001 (4)
  - an = 1101 with seg = 0110000 (3)
  - an = 1011 with seg = 0100100 (2)
  - an = 0111 with seg = 1111001 (1)
  - each digit lit for 4 cycles.
- D = 10000, then D = 65535 → ovf = 1, all four digits = 0111111. Then D = 9999 → ovf = 0, all digits = 0010000.
- D = 7 with LEAD_ZERO_BLANK_EN → ones digit 1111000, other three digits 1111111. Without the macro: ones digit 1111000, other three digits 1000000.
- Mid-conversion change: D = 1111, then at cycle 5 of SHIFT D = 42 → the first result shows 1111. busy is low one cycle, then reconverts. The final display is 0042 (or blank-blank-4-2 with the macro).
- clear at SHIFT cycle 8 while converting D = 5000 → next cycle dig = 0000, busy = 0, an = 1110. After clear drops, D = 5000 ≠ last = 0 triggers a fresh conversion to 5000.
